music_player_ctrl: RTL and testbench
====================================

Name: music_player_ctrl

Overview:
- Playback controller for the ROM-based music player.
- Three functions:
  - play/pause toggle;
  - current-song selection (2-bit select, 4 songs);
  - current sample-address counter with +/-10 s and +/-30 s seek.
- Drives the 24-bit ROM address {select, endereco} and reads back the ROM byte to detect end-of-song, which auto-advances to the next song.

Parameters:
- SAMPLES_PER_SEC, 8000, address increments per second of audio; the seek step is N*SAMPLES_PER_SEC.
- CLKS_PER_SAMPLE, 1, clock cycles per address increment while playing (1 = every cycle).
- END_MARKER, 8'hFF, ROM byte value that marks end of song.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- play_pause  in  1  level button; rising edge toggles play.
- prox  in  1  level button; rising edge selects next song.
- prev  in  1  level button; rising edge selects previous song.
- passa_10s  in  1  button: seek +10 s.
- volta_10s  in  1  button: seek -10 s.
- passa_30s  in  1  button: seek +30 s.
- volta_30s  in  1  button: seek -30 s.
- current_value  in  8  ROM data at full_addr.
- play  out  1  1 = playing, 0 = paused.
- select  out  2  current song index.
- endereco  out  22  sample address within the song.
- full_addr  out  24  {select, endereco}, combinational.
- time_adder  out  9 signed  seconds of the last applied seek (+10/-10/+30/-30), 0 when none.
- prox_musica  out  1  one-cycle pulse: end of song reached.
- start  out  1  one-cycle pulse: song changed, address restarting.

Behaviour:
- Reset values: play=0, select=0, endereco=0, time_adder=0, prox_musica=0, start=0, sample divider=0, all edge-detector history=0.
- Edge detection: each button is registered once. pulse = btn & ~btn_q.
  - State changes at the first rising clk edge where the button is sampled high.
  - A held button acts once; it must return low before it can act again.
- Play/pause: pulse toggles play at that edge.
- Song select: at an edge, priority is:
  - prox_musica: select+1;
  - otherwise prox without prev: select+1;
  - otherwise prev without prox: select-1;
  - prox and prev together: no change.
  - Wraps modulo 4 (3->0, 0->3).
  - Any select change sets start=1 for exactly the next cycle.
- Address counter, priority per edge:
  1. start=1: endereco<=0, time_adder<=0, divider cleared.
  2. prox_musica=1: hold.
  3. Seek pulse.
     - Fixed order when several seek pulses coincide: passa_30s > volta_30s > passa_10s > volta_10s.
     - New address = endereco +/- N*SAMPLES_PER_SEC, computed in 23+ bits.
     - Negative results saturate to 0; results above 2^22-1 saturate to 2^22-1.
     - time_adder <= +/-N. Seek works while paused. The divider is cleared.
  4. play=1: divider counts to CLKS_PER_SAMPLE-1, then endereco+1.
  5. Else hold.
- End of song:
  - Condition: play=1 and (current_value==END_MARKER, or endereco==2^22-1 at an increment).
  - Sets prox_musica=1 for one cycle.
  - Suppressed while prox_musica or start is already 1.
  - Sequence:
    - edge n: prox_musica=1;
    - edge n+1: select+1, start=1, prox_musica=0;
    - edge n+2: endereco=0, start=0.
  - play stays 1 across the song change.
- Manual prox/prev goes through the same start path: address is 0 two edges after the button pulse.
- Asserting reset at any point returns every output to its reset value immediately; no pending pulse survives reset.

Decomposition:
- Shared package music_ctrl_pkg holds:
  - ADDR_W=22, SEL_W=2, DATA_W=8;
  - the seek step constants (10, 30);
  - the default END_MARKER.
- One natural sub-module: btn_edge (register + rising-edge pulse), instantiated for each of the 7 buttons.
- Select logic, play toggle and address counter are always blocks in the top.

Test Plan (SAMPLES_PER_SEC=4, CLKS_PER_SAMPLE=1, ROM model returns 8'h00 except END_MARKER at chosen address):
- Reset, then play_pause high 5 cycles -> play=1 after first edge only. endereco increments 1 per cycle. Second press -> play=0, endereco frozen.
- At endereco=7, pulse passa_10s -> endereco=47, time_adder=+10. Then passa_30s -> 167, time_adder=+30.
- At endereco=20, pulse volta_30s -> endereco=0 (saturated), time_adder=-30. With endereco=2^22-10, passa_30s -> 2^22-1.
- select=3, press prox -> select=0, start pulse next cycle, endereco=0 two edges after. select=0, press prev -> select=3. prox+prev together -> select unchanged, no start.
- Playing, ROM returns 8'hFF at endereco=12 -> prox_musica one cycle, select+1, start one cycle, endereco=0, play still 1. Paused at the marker -> no prox_musica.
- Assert reset mid-seek and mid-start sequence -> all outputs 0 immediately. No residual prox_musica/start after release.

Source files
------------

// File: rtl/music_ctrl_pkg.sv
// Shared widths, seek constants and helpers for the ROM music player controller.
package music_ctrl_pkg;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DATA_W = 8;

  localparam int SEEK_SHORT_S = 10;
  localparam int SEEK_LONG_S  = 30;

  localparam logic [DATA_W-1:0] END_MARKER_DEF = 8'hFF;

  localparam int unsigned NUM_BTN      = 7;
  localparam int unsigned BTN_PLAY     = 0;
  localparam int unsigned BTN_PROX     = 1;
  localparam int unsigned BTN_PREV     = 2;
  localparam int unsigned BTN_PASSA_10 = 3;
  localparam int unsigned BTN_VOLTA_10 = 4;
  localparam int unsigned BTN_PASSA_30 = 5;
  localparam int unsigned BTN_VOLTA_30 = 6;

  typedef enum logic [2:0] {
    SEEK_NONE,
    SEEK_FWD30,
    SEEK_BACK30,
    SEEK_FWD10,
    SEEK_BACK10
  } seek_e;

  function automatic logic signed [8:0] seek_secs(input seek_e s);
    case (s)
      SEEK_FWD30:  return 9'sd30;
      SEEK_BACK30: return -9'sd30;
      SEEK_FWD10:  return 9'sd10;
      SEEK_BACK10: return -9'sd10;
      default:     return '0;
    endcase
  endfunction

endpackage

// File: rtl/music_player_ctrl_btn_edge.sv
// One-register rising-edge detector: a held button yields a single-cycle pulse.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn_i;
  end

  assign pulse_o = btn_i & ~btn_q;

endmodule

// File: rtl/music_player_ctrl.sv
// Playback controller: play/pause, song select, sample address with saturating seek,
// and end-of-song auto-advance driven by the ROM byte read back at full_addr.
module music_player_ctrl
  import music_ctrl_pkg::*;
#(
  parameter int unsigned        SAMPLES_PER_SEC = 8000,
  parameter int unsigned        CLKS_PER_SAMPLE = 1,
  parameter logic [DATA_W-1:0]  END_MARKER      = END_MARKER_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_pause,
  input  logic                prox,
  input  logic                prev,
  input  logic                passa_10s,
  input  logic                volta_10s,
  input  logic                passa_30s,
  input  logic                volta_30s,
  input  logic [DATA_W-1:0]   current_value,
  output logic                play,
  output logic [SEL_W-1:0]    select,
  output logic [ADDR_W-1:0]   endereco,
  output logic [SEL_W+ADDR_W-1:0] full_addr,
  output logic signed [8:0]   time_adder,
  output logic                prox_musica,
  output logic                start
);

  localparam int unsigned DIV_W  = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);
  localparam int unsigned SUM_W  = ADDR_W + 10;
  localparam int STEP10 = SEEK_SHORT_S * int'(SAMPLES_PER_SEC);
  localparam int STEP30 = SEEK_LONG_S * int'(SAMPLES_PER_SEC);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-ADDR_W){1'b0}}, ADDR_MAX};

  logic [NUM_BTN-1:0] btn_raw, btn_pulse;

  assign btn_raw = {volta_30s, passa_30s, volta_10s, passa_10s, prev, prox, play_pause};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_edge u_edge (
      .clk     (clk),
      .rst     (reset),
      .btn_i   (btn_raw[g]),
      .pulse_o (btn_pulse[g])
    );
  end

  logic                     play_q, play_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic signed [8:0]        ta_q, ta_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic                     pm_q, pm_d;
  logic                     start_q, start_d;

  seek_e                    seek;
  logic                     inc;
  logic signed [SUM_W-1:0]  seek_delta, seek_sum;

  always_comb begin
    seek = SEEK_NONE;
    if      (btn_pulse[BTN_PASSA_30]) seek = SEEK_FWD30;
    else if (btn_pulse[BTN_VOLTA_30]) seek = SEEK_BACK30;
    else if (btn_pulse[BTN_PASSA_10]) seek = SEEK_FWD10;
    else if (btn_pulse[BTN_VOLTA_10]) seek = SEEK_BACK10;
  end

  always_comb begin
    case (seek)
      SEEK_FWD30:  seek_delta = SUM_W'(STEP30);
      SEEK_BACK30: seek_delta = -SUM_W'(STEP30);
      SEEK_FWD10:  seek_delta = SUM_W'(STEP10);
      SEEK_BACK10: seek_delta = -SUM_W'(STEP10);
      default:     seek_delta = '0;
    endcase
    seek_sum = $signed({{(SUM_W-ADDR_W){1'b0}}, addr_q}) + seek_delta;
  end

  // Address path; the top address holds rather than wraps, end-of-song handles it.
  always_comb begin
    addr_d = addr_q;
    ta_d   = ta_q;
    div_d  = div_q;
    inc    = 1'b0;
    if (start_q) begin
      addr_d = '0;
      ta_d   = '0;
      div_d  = '0;
    end else if (pm_q) begin
      addr_d = addr_q;
    end else if (seek != SEEK_NONE) begin
      ta_d  = seek_secs(seek);
      div_d = '0;
      if (seek_sum[SUM_W-1])       addr_d = '0;
      else if (seek_sum > SUM_MAX) addr_d = ADDR_MAX;
      else                         addr_d = seek_sum[ADDR_W-1:0];
    end else if (play_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        inc   = 1'b1;
        if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    play_d = play_q ^ btn_pulse[BTN_PLAY];
    sel_d  = sel_q;
    if (pm_q)
      sel_d = sel_q + SEL_W'(1);
    else if (btn_pulse[BTN_PROX] && !btn_pulse[BTN_PREV])
      sel_d = sel_q + SEL_W'(1);
    else if (btn_pulse[BTN_PREV] && !btn_pulse[BTN_PROX])
      sel_d = sel_q - SEL_W'(1);
    start_d = (sel_d != sel_q);
    pm_d    = play_q && !pm_q && !start_q &&
              ((current_value == END_MARKER) || (inc && (addr_q == ADDR_MAX)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      play_q  <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      ta_q    <= '0;
      div_q   <= '0;
      pm_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      play_q  <= play_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      ta_q    <= ta_d;
      div_q   <= div_d;
      pm_q    <= pm_d;
      start_q <= start_d;
    end
  end

  assign play        = play_q;
  assign select      = sel_q;
  assign endereco    = addr_q;
  assign full_addr   = {sel_q, addr_q};
  assign time_adder  = ta_q;
  assign prox_musica = pm_q;
  assign start       = start_q;

endmodule

// File: tb/tb_music_player_ctrl.sv
// Scoreboard bench: stimulus queues hand-computed expectations tagged with a cycle,
// a negedge monitor compares them against the selected DUT instance.
module tb_music_player_ctrl;

  localparam bit [5:0] M_PLAY = 6'b000001;
  localparam bit [5:0] M_SEL  = 6'b000010;
  localparam bit [5:0] M_ADDR = 6'b000100;
  localparam bit [5:0] M_TA   = 6'b001000;
  localparam bit [5:0] M_PM   = 6'b010000;
  localparam bit [5:0] M_ST   = 6'b100000;
  localparam bit [5:0] M_ALL  = 6'b111111;
  localparam int AMAX = 4194303;

  typedef struct {
    string    nm;
    int       cyc;
    bit       i2;
    bit [5:0] m;
    bit       pl;
    int       sl;
    int       ad;
    int       ta;
    bit       pm;
    bit       st;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic clk = 1'b0;
  logic reset;
  logic pp, prox, prev, p10, v10, p30, v30;
  logic pp2, p10_2, p30_2, zero2;
  logic mk_en;
  logic [23:0] mk_addr;
  logic [7:0] rom1, rom2;

  logic        play1, play2, pm1, pm2, st1, st2;
  logic [1:0]  sel1, sel2;
  logic [21:0] addr1, addr2;
  logic [23:0] full1, full2;
  logic signed [8:0] ta1, ta2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom1 = (mk_en && full1 == mk_addr) ? 8'hFF : 8'h00;
  assign rom2 = 8'h00;

  music_player_ctrl #(.SAMPLES_PER_SEC(4), .CLKS_PER_SAMPLE(1), .END_MARKER(8'hFF)) dut (
    .clk(clk), .reset(reset), .play_pause(pp), .prox(prox), .prev(prev),
    .passa_10s(p10), .volta_10s(v10), .passa_30s(p30), .volta_30s(v30),
    .current_value(rom1), .play(play1), .select(sel1), .endereco(addr1),
    .full_addr(full1), .time_adder(ta1), .prox_musica(pm1), .start(st1)
  );

  music_player_ctrl #(.SAMPLES_PER_SEC(139810), .CLKS_PER_SAMPLE(1), .END_MARKER(8'hFF)) dut2 (
    .clk(clk), .reset(reset), .play_pause(pp2), .prox(zero2), .prev(zero2),
    .passa_10s(p10_2), .volta_10s(zero2), .passa_30s(p30_2), .volta_30s(zero2),
    .current_value(rom2), .play(play2), .select(sel2), .endereco(addr2),
    .full_addr(full2), .time_adder(ta2), .prox_musica(pm2), .start(st2)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ex(input string nm, input int d, input bit i2, input bit [5:0] m,
                    input bit pl, input int sl, input int ad, input int ta,
                    input bit pm, input bit st);
    exp_t e;
    e.nm = nm; e.cyc = cyc + d; e.i2 = i2; e.m = m;
    e.pl = pl; e.sl = sl; e.ad = ad; e.ta = ta; e.pm = pm; e.st = st;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    int i;
    exp_t e;
    bit ok;
    bit a_pl, a_pm, a_st;
    int a_sl, a_ad, a_ta;
    logic [23:0] a_full, e_full;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        e = sb[i];
        sb.delete(i);
        a_pl   = e.i2 ? play2 : play1;
        a_sl   = e.i2 ? int'(sel2) : int'(sel1);
        a_ad   = e.i2 ? int'(addr2) : int'(addr1);
        a_ta   = e.i2 ? int'(ta2) : int'(ta1);
        a_pm   = e.i2 ? pm2 : pm1;
        a_st   = e.i2 ? st2 : st1;
        a_full = e.i2 ? full2 : full1;
        e_full = {2'(e.sl), 22'(e.ad)};
        ok = 1'b1;
        if (e.m[0] && a_pl != e.pl) ok = 1'b0;
        if (e.m[1] && a_sl != e.sl) ok = 1'b0;
        if (e.m[2] && a_ad != e.ad) ok = 1'b0;
        if (e.m[3] && a_ta != e.ta) ok = 1'b0;
        if (e.m[4] && a_pm != e.pm) ok = 1'b0;
        if (e.m[5] && a_st != e.st) ok = 1'b0;
        if (e.m[1] && e.m[2] && a_full != e_full) ok = 1'b0;
        n_tests++;
        if (!ok) begin
          n_fail++;
          $display("FAIL %s cyc=%0d mask=%b got play=%0b sel=%0d addr=%0d ta=%0d pm=%0b st=%0b full=%h want play=%0b sel=%0d addr=%0d ta=%0d pm=%0b st=%0b full=%h",
                   e.nm, cyc, e.m, a_pl, a_sl, a_ad, a_ta, a_pm, a_st, a_full,
                   e.pl, e.sl, e.ad, e.ta, e.pm, e.st, e_full);
        end
      end else begin
        i++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    pp = 0; prox = 0; prev = 0; p10 = 0; v10 = 0; p30 = 0; v30 = 0;
    pp2 = 0; p10_2 = 0; p30_2 = 0; zero2 = 0; mk_en = 0; mk_addr = '0;
    tick(2);
    ex("reset1", 0, 0, M_ALL, 0, 0, 0, 0, 0, 0);
    ex("reset2", 0, 1, M_ALL, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick(1);

    // upper saturation and end-of-song at the last address
    p30_2 = 1;
    ex("sat_fwd30", 1, 1, M_PLAY | M_ADDR | M_TA, 0, 0, 4194300, 30, 0, 0);
    tick(1);
    p30_2 = 0; p10_2 = 1;
    ex("sat_hi", 1, 1, M_PLAY | M_ADDR | M_TA, 0, 0, AMAX, 10, 0, 0);
    tick(1);
    p10_2 = 0; pp2 = 1;
    tick(1);
    pp2 = 0;
    ex("max_eos_pm",    1, 1, M_PLAY | M_SEL | M_PM | M_ST, 1, 0, 0, 0, 1, 0);
    ex("max_eos_start", 2, 1, M_PLAY | M_SEL | M_PM | M_ST, 1, 1, 0, 0, 0, 1);
    ex("max_eos_clear", 3, 1, M_ALL, 1, 1, 0, 0, 0, 0);
    tick(3);
    pp2 = 1; tick(1); pp2 = 0; tick(1);

    // play/pause with a held button
    pp = 1;
    ex("play_on",   1, 0, M_PLAY | M_ADDR, 1, 0, 0, 0, 0, 0);
    ex("play_held", 2, 0, M_PLAY | M_ADDR, 1, 0, 1, 0, 0, 0);
    ex("play_run",  5, 0, M_PLAY | M_ADDR, 1, 0, 4, 0, 0, 0);
    tick(5);
    pp = 0; tick(1);
    pp = 1;
    ex("pause", 1, 0, M_PLAY | M_ADDR, 0, 0, 6, 0, 0, 0);
    tick(1);
    pp = 0;
    ex("paused_frozen", 3, 0, M_PLAY | M_ADDR, 0, 0, 6, 0, 0, 0);
    tick(3);

    // forward seeks while playing
    pp = 1; tick(1); pp = 0; tick(1);
    ex("at7", 0, 0, M_PLAY | M_ADDR, 1, 0, 7, 0, 0, 0);
    p10 = 1;
    ex("fwd10", 1, 0, M_ADDR | M_TA, 0, 0, 47, 10, 0, 0);
    tick(1);
    p10 = 0; p30 = 1;
    ex("fwd30", 1, 0, M_ADDR | M_TA, 0, 0, 167, 30, 0, 0);
    tick(1);
    p30 = 0; pp = 1;
    ex("pause2", 1, 0, M_PLAY | M_ADDR | M_TA, 0, 0, 168, 30, 0, 0);
    tick(1);
    pp = 0; tick(1);

    // backward seeks, lower saturation
    v30 = 1;
    ex("back30", 1, 0, M_ADDR | M_TA, 0, 0, 48, -30, 0, 0);
    tick(1);
    v30 = 0; v10 = 1;
    ex("back10", 1, 0, M_ADDR | M_TA, 0, 0, 8, -10, 0, 0);
    tick(1);
    v10 = 0; pp = 1; tick(1); pp = 0; tick(12);
    ex("at20", 0, 0, M_PLAY | M_ADDR | M_TA, 1, 0, 20, -10, 0, 0);
    v30 = 1;
    ex("back30_sat", 1, 0, M_ADDR | M_TA, 0, 0, 0, -30, 0, 0);
    tick(1);
    v30 = 0; pp = 1;
    ex("pause3", 1, 0, M_PLAY | M_ADDR, 0, 0, 1, 0, 0, 0);
    tick(1);
    pp = 0; tick(1);

    // coincident seek priority
    p30 = 1; v30 = 1; p10 = 1; v10 = 1;
    ex("prio_all", 1, 0, M_ADDR | M_TA, 0, 0, 121, 30, 0, 0);
    tick(1);
    p30 = 0; v30 = 0; p10 = 0; v10 = 0; tick(1);
    v30 = 1; p10 = 1; v10 = 1;
    ex("prio_v30", 1, 0, M_ADDR | M_TA, 0, 0, 1, -30, 0, 0);
    tick(1);
    v30 = 0; p10 = 0; v10 = 0; tick(1);
    p10 = 1; v10 = 1;
    ex("prio_p10", 1, 0, M_ADDR | M_TA, 0, 0, 41, 10, 0, 0);
    tick(1);
    p10 = 0; v10 = 0; tick(1);

    // song select
    prev = 1;
    ex("prev_wrap",  1, 0, M_SEL | M_ST | M_ADDR | M_TA, 0, 3, 41, 10, 0, 1);
    ex("prev_clear", 2, 0, M_SEL | M_ST | M_ADDR | M_TA, 0, 3, 0, 0, 0, 0);
    ex("prev_held",  3, 0, M_SEL | M_ST, 0, 3, 0, 0, 0, 0);
    tick(3);
    prev = 0; tick(1);
    p10 = 1; tick(1); p10 = 0;
    prox = 1;
    ex("prox_wrap",  1, 0, M_SEL | M_ST | M_ADDR | M_TA, 0, 0, 40, 10, 0, 1);
    ex("prox_clear", 2, 0, M_SEL | M_ST | M_ADDR | M_TA, 0, 0, 0, 0, 0, 0);
    tick(1);
    prox = 0; tick(2);
    prox = 1; prev = 1;
    ex("both1", 1, 0, M_SEL | M_ST, 0, 0, 0, 0, 0, 0);
    ex("both2", 2, 0, M_SEL | M_ST, 0, 0, 0, 0, 0, 0);
    tick(2);
    prox = 0; prev = 0; tick(1);

    // end-of-song marker at song 0, address 12
    mk_en = 1; mk_addr = {2'd0, 22'd12};
    pp = 1; tick(1); pp = 0;
    ex("eos_pre",   12, 0, M_PLAY | M_SEL | M_ADDR | M_PM | M_ST, 1, 0, 12, 0, 0, 0);
    ex("eos_pm",    13, 0, M_PLAY | M_SEL | M_ADDR | M_PM | M_ST, 1, 0, 13, 0, 1, 0);
    ex("eos_start", 14, 0, M_PLAY | M_SEL | M_ADDR | M_PM | M_ST, 1, 1, 13, 0, 0, 1);
    ex("eos_clear", 15, 0, M_ALL, 1, 1, 0, 0, 0, 0);
    ex("eos_run",   16, 0, M_PLAY | M_SEL | M_ADDR | M_PM | M_ST, 1, 1, 1, 0, 0, 0);
    tick(16);
    pp = 1;
    ex("pause_eos", 1, 0, M_PLAY | M_SEL | M_ADDR, 0, 1, 2, 0, 0, 0);
    tick(1);
    pp = 0; mk_addr = {2'd1, 22'd2};
    ex("paused_marker1", 1, 0, M_PLAY | M_SEL | M_ADDR | M_PM | M_ST, 0, 1, 2, 0, 0, 0);
    ex("paused_marker2", 2, 0, M_PLAY | M_SEL | M_ADDR | M_PM | M_ST, 0, 1, 2, 0, 0, 0);
    ex("paused_marker3", 3, 0, M_PLAY | M_SEL | M_ADDR | M_PM | M_ST, 0, 1, 2, 0, 0, 0);
    tick(3);
    mk_en = 0;

    // asynchronous reset mid-seek and mid-start
    p30 = 1; tick(1);
    reset = 1; p30 = 0;
    ex("rst_seek", 0, 0, M_ALL, 0, 0, 0, 0, 0, 0);
    tick(1);
    reset = 0;
    ex("rst_seek_after", 1, 0, M_ALL, 0, 0, 0, 0, 0, 0);
    tick(2);
    prox = 1; tick(1);
    reset = 1; prox = 0;
    ex("rst_start",  0, 0, M_ALL, 0, 0, 0, 0, 0, 0);
    ex("rst_start2", 0, 1, M_ALL, 0, 0, 0, 0, 0, 0);
    tick(1);
    reset = 0;
    ex("rst_start_after1", 1, 0, M_ALL, 0, 0, 0, 0, 0, 0);
    ex("rst_start_after2", 2, 0, M_ALL, 0, 0, 0, 0, 0, 0);
    tick(3);

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain pending=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
